// File: rtl/pipeline_stall_ctrl.sv
// ============================================================================
// pipeline_stall_ctrl
// ----------------------------------------------------------------------------
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
//   - Detects load-use hazards between the EX load and the ID read ports.
//   - Holds EX while a multi-cycle MULT/DIV occupies the MDU.
//   - Propagates memory-wait and flush requests.
//   - Counts cycles with any stall asserted, for profiling.
//
// Parameters
//   MULT_CYCLES : EX occupancy of MULT/MULTU in cycles (>=1)
//   DIV_CYCLES  : EX occupancy of DIV/DIVU in cycles (>=1)
//   CNT_W       : width of the MDU cycle counter (holds DIV_CYCLES-1)
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   id_read_en_1/2      : ID read port enables
//   id_reg_addr_1/2     : ID read port addresses
//   ex_write_reg_en     : EX instruction writes a GPR
//   ex_write_reg_addr   : EX destination GPR
//   ex_is_load          : EX instruction is a load
//   ex_mdu_start        : EX holds a MULT/DIV that has not started yet
//   ex_mdu_div          : 1 = DIV class, 0 = MULT class
//   mem_stall_req       : MEM data access not ready
//   flush_req           : kill IF..MEM contents
//   stall[4:0]          : hold for [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB
//   flush               : clear IF/ID, ID/EX, EX/MEM to NOP this cycle
//   mdu_busy            : MDU occupying EX
//   mdu_done            : one-cycle pulse, MDU result valid
//   stall_cycles        : wrapping count of cycles with stall != 0
//
// A register k+1 whose neighbour k is held but which is itself not held
// loads a NOP (bubble); that is done by the pipeline registers themselves.
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 2,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_read_en_1,
    input  logic [4:0]  id_reg_addr_1,
    input  logic        id_read_en_2,
    input  logic [4:0]  id_reg_addr_2,
    input  logic        ex_write_reg_en,
    input  logic [4:0]  ex_write_reg_addr,
    input  logic        ex_is_load,
    input  logic        ex_mdu_start,
    input  logic        ex_mdu_div,
    input  logic        mem_stall_req,
    input  logic        flush_req,
    output logic [4:0]  stall,
    output logic        flush,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] stall_cycles
);

    // Stall vectors, one per cause.
    localparam logic [4:0] STALL_NONE = 5'b00000;
    localparam logic [4:0] STALL_MEM  = 5'b01111;
    localparam logic [4:0] STALL_MDU  = 5'b00111;
    localparam logic [4:0] STALL_LU   = 5'b00011;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE,
        MDU_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic load_use;
    logic cnt_zero;
    logic mdu_hold;
    logic mdu_fin;
    logic port1_hit;
    logic port2_hit;

    // ------------------------------------------------------------------------
    // Load-use hazard: purely combinational, lasts exactly the cycle in which
    // the load sits in EX and the consumer sits in ID. $0 never hazards.
    // ------------------------------------------------------------------------
    always_comb begin
        port1_hit = id_read_en_1 && (id_reg_addr_1 == ex_write_reg_addr);
        port2_hit = id_read_en_2 && (id_reg_addr_2 == ex_write_reg_addr);
        load_use  = ex_is_load && ex_write_reg_en &&
                    (ex_write_reg_addr != 5'd0) && (port1_hit || port2_hit);
    end

    // ------------------------------------------------------------------------
    // MDU hold. EX stays held through the mdu_done cycle as well, so a MULT
    // stalls for MULT_CYCLES+1 cycles (start cycle included) and the
    // instruction leaves EX on the cycle after mdu_done. The datapath clears
    // its "not started" flag on mdu_done, so ex_mdu_start is low by then.
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_zero = (cnt == '0);
        mdu_hold = ((state == IDLE) && ex_mdu_start) || (state == MDU_WAIT);
        mdu_fin  = (state == MDU_WAIT) && cnt_zero && !mem_stall_req;
    end

    // ------------------------------------------------------------------------
    // Output decode, priority flush > mem > mdu > load-use.
    // Everything is forced low while rst is asserted.
    // ------------------------------------------------------------------------
    always_comb begin
        stall    = STALL_NONE;
        flush    = 1'b0;
        mdu_busy = 1'b0;
        mdu_done = 1'b0;
        if (!rst) begin
            mdu_busy = (state == MDU_WAIT);
            // A flush kills the MDU instruction, so no completion pulse.
            mdu_done = mdu_fin && !flush_req;
            if (flush_req) begin
                flush = 1'b1;
            end else if (mem_stall_req) begin
                stall = STALL_MEM;
            end else if (mdu_hold) begin
                stall = STALL_MDU;
            end else if (load_use) begin
                stall = STALL_LU;
            end
        end
    end

    // ------------------------------------------------------------------------
    // MDU sequencer and profiling counter.
    // The countdown keeps running under mem_stall_req and saturates at 0;
    // completion waits for the memory stall to clear.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            if (stall != STALL_NONE) begin
                stall_cycles <= stall_cycles + 32'd1;
            end

            if (flush_req) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ex_mdu_start) begin
                            state <= MDU_WAIT;
                            cnt   <= ex_mdu_div ? DIV_LOAD : MULT_LOAD;
                        end
                    end
                    MDU_WAIT: begin
                        if (mdu_fin) begin
                            state <= IDLE;
                        end
                        if (!cnt_zero) begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ============================================================================
// tb_pipeline_stall_ctrl
// Directed bench for pipeline_stall_ctrl with default parameters
// (MULT_CYCLES=2, DIV_CYCLES=32). Inputs are driven at the falling edge,
// outputs are checked 1ns later, well clear of the rising edge.
// ============================================================================
module tb_pipeline_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        id_read_en_1;
    logic [4:0]  id_reg_addr_1;
    logic        id_read_en_2;
    logic [4:0]  id_reg_addr_2;
    logic        ex_write_reg_en;
    logic [4:0]  ex_write_reg_addr;
    logic        ex_is_load;
    logic        ex_mdu_start;
    logic        ex_mdu_div;
    logic        mem_stall_req;
    logic        flush_req;
    logic [4:0]  stall;
    logic        flush;
    logic        mdu_busy;
    logic        mdu_done;
    logic [31:0] stall_cycles;

    int unsigned n_pass;
    int unsigned n_total;
    int unsigned exp_cnt;   // expected stall_cycles, bumped per stalled cycle

    pipeline_stall_ctrl #(
        .MULT_CYCLES(2),
        .DIV_CYCLES (32),
        .CNT_W      (6)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_read_en_1     (id_read_en_1),
        .id_reg_addr_1    (id_reg_addr_1),
        .id_read_en_2     (id_read_en_2),
        .id_reg_addr_2    (id_reg_addr_2),
        .ex_write_reg_en  (ex_write_reg_en),
        .ex_write_reg_addr(ex_write_reg_addr),
        .ex_is_load       (ex_is_load),
        .ex_mdu_start     (ex_mdu_start),
        .ex_mdu_div       (ex_mdu_div),
        .mem_stall_req    (mem_stall_req),
        .flush_req        (flush_req),
        .stall            (stall),
        .flush            (flush),
        .mdu_busy         (mdu_busy),
        .mdu_done         (mdu_done),
        .stall_cycles     (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_read_en_1      = 1'b0;
        id_reg_addr_1     = 5'd0;
        id_read_en_2      = 1'b0;
        id_reg_addr_2     = 5'd0;
        ex_write_reg_en   = 1'b0;
        ex_write_reg_addr = 5'd0;
        ex_is_load        = 1'b0;
        ex_mdu_start      = 1'b0;
        ex_mdu_div        = 1'b0;
        mem_stall_req     = 1'b0;
        flush_req         = 1'b0;
    endtask

    // Advance to the next falling edge (one rising edge passes).
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst           = 1'b1;
        ex_mdu_start  = 1'b1;
        mem_stall_req = 1'b1;
        flush_req     = 1'b1;
        tick();
        tick();
        #1;
        n_total++;
        if ({stall, flush, mdu_busy, mdu_done} !== 8'h00)
            $display("FAIL reset_outputs: got stall=%b flush=%b busy=%b done=%b, want all 0",
                     stall, flush, mdu_busy, mdu_done);
        else n_pass++;
        n_total++;
        if (stall_cycles !== 32'd0)
            $display("FAIL reset_counter: got %0d, want 0", stall_cycles);
        else n_pass++;
        clear_inputs();
        rst = 1'b0;
        #1;
        n_total++;
        if ({stall, flush, mdu_busy, mdu_done} !== 8'h00)
            $display("FAIL idle_after_reset: got stall=%b flush=%b busy=%b done=%b, want all 0",
                     stall, flush, mdu_busy, mdu_done);
        else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        // lw $3 in EX, ID reads $3 on port 1
        clear_inputs();
        ex_is_load = 1'b1; ex_write_reg_en = 1'b1; ex_write_reg_addr = 5'd3;
        id_read_en_1 = 1'b1; id_reg_addr_1 = 5'd3;
        #1;
        n_total++;
        if (stall !== 5'b00011) $display("FAIL load_use_p1: got %b, want 00011", stall);
        else n_pass++;
        exp_cnt++;
        tick();
        // load has moved on; consumer now in EX
        clear_inputs();
        id_read_en_1 = 1'b1; id_reg_addr_1 = 5'd3;
        #1;
        n_total++;
        if (stall !== 5'b00000) $display("FAIL load_use_release: got %b, want 00000", stall);
        else n_pass++;
        tick();
        // port 2 match, port 1 mismatch
        clear_inputs();
        ex_is_load = 1'b1; ex_write_reg_en = 1'b1; ex_write_reg_addr = 5'd7;
        id_read_en_1 = 1'b1; id_reg_addr_1 = 5'd6;
        id_read_en_2 = 1'b1; id_reg_addr_2 = 5'd7;
        #1;
        n_total++;
        if (stall !== 5'b00011) $display("FAIL load_use_p2: got %b, want 00011", stall);
        else n_pass++;
        exp_cnt++;
        tick();
    endtask

    task automatic test_no_hazard();
        // lw $0 with ID reading $0
        clear_inputs();
        ex_is_load = 1'b1; ex_write_reg_en = 1'b1; ex_write_reg_addr = 5'd0;
        id_read_en_1 = 1'b1; id_reg_addr_1 = 5'd0;
        id_read_en_2 = 1'b1; id_reg_addr_2 = 5'd0;
        #1;
        n_total++;
        if (stall !== 5'b00000) $display("FAIL r0_exempt: got %b, want 00000", stall);
        else n_pass++;
        tick();
        // matching addresses but read enables low
        clear_inputs();
        ex_is_load = 1'b1; ex_write_reg_en = 1'b1; ex_write_reg_addr = 5'd5;
        id_reg_addr_1 = 5'd5; id_reg_addr_2 = 5'd5;
        #1;
        n_total++;
        if (stall !== 5'b00000) $display("FAIL read_en_low: got %b, want 00000", stall);
        else n_pass++;
        tick();
        // matching but EX is not a load
        clear_inputs();
        ex_write_reg_en = 1'b1; ex_write_reg_addr = 5'd9;
        id_read_en_1 = 1'b1; id_reg_addr_1 = 5'd9;
        #1;
        n_total++;
        if (stall !== 5'b00000) $display("FAIL not_load: got %b, want 00000", stall);
        else n_pass++;
        tick();
    endtask

    task automatic test_mult();
        logic [7:0] exp_vec [3];
        exp_vec[0] = {5'b00111, 1'b0, 1'b0, 1'b0};
        exp_vec[1] = {5'b00111, 1'b0, 1'b1, 1'b0};
        exp_vec[2] = {5'b00111, 1'b0, 1'b1, 1'b1};
        clear_inputs();
        ex_mdu_start = 1'b1; ex_mdu_div = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // a load-use pattern on top must be masked by the MDU hold
            ex_is_load = 1'b1; ex_write_reg_en = 1'b1; ex_write_reg_addr = 5'd4;
            id_read_en_1 = 1'b1; id_reg_addr_1 = 5'd4;
            #1;
            n_total++;
            if ({stall, flush, mdu_busy, mdu_done} !== exp_vec[i])
                $display("FAIL mult_cycle%0d: got stall=%b flush=%b busy=%b done=%b, want %b",
                         i, stall, flush, mdu_busy, mdu_done, exp_vec[i]);
            else n_pass++;
            exp_cnt++;
            tick();
        end
        clear_inputs();
        #1;
        n_total++;
        if ({stall, mdu_busy, mdu_done} !== 7'b0000000)
            $display("FAIL mult_exit: got stall=%b busy=%b done=%b, want 0", stall, mdu_busy, mdu_done);
        else n_pass++;
        tick();
    endtask

    task automatic test_div_mem();
        clear_inputs();
        ex_mdu_start = 1'b1; ex_mdu_div = 1'b1; mem_stall_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            n_total++;
            if (stall !== 5'b01111 || mdu_done !== 1'b0 || mdu_busy !== (i != 0))
                $display("FAIL div_mem_cycle%0d: got stall=%b busy=%b done=%b, want 01111 busy=%0d done=0",
                         i, stall, mdu_busy, mdu_done, (i != 0));
            else n_pass++;
            exp_cnt++;
            tick();
        end
        mem_stall_req = 1'b0;
        #1;
        n_total++;
        if (stall !== 5'b00111 || mdu_done !== 1'b1 || mdu_busy !== 1'b1)
            $display("FAIL div_mem_done: got stall=%b busy=%b done=%b, want 00111 busy=1 done=1",
                     stall, mdu_busy, mdu_done);
        else n_pass++;
        exp_cnt++;
        tick();
        clear_inputs();
        #1;
        n_total++;
        if ({stall, mdu_busy, mdu_done} !== 7'b0000000)
            $display("FAIL div_mem_exit: got stall=%b busy=%b done=%b, want 0", stall, mdu_busy, mdu_done);
        else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        clear_inputs();
        ex_mdu_start = 1'b1; ex_mdu_div = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++;
            if (stall !== 5'b00111)
                $display("FAIL flush_div_cycle%0d: got %b, want 00111", i, stall);
            else n_pass++;
            exp_cnt++;
            tick();
        end
        flush_req = 1'b1;
        #1;
        n_total++;
        if (stall !== 5'b00000 || flush !== 1'b1 || mdu_done !== 1'b0)
            $display("FAIL flush_cycle: got stall=%b flush=%b done=%b, want 00000 1 0",
                     stall, flush, mdu_done);
        else n_pass++;
        tick();
        clear_inputs();
        #1;
        n_total++;
        if ({stall, flush, mdu_busy, mdu_done} !== 8'h00)
            $display("FAIL flush_idle: got stall=%b flush=%b busy=%b done=%b, want all 0",
                     stall, flush, mdu_busy, mdu_done);
        else n_pass++;
        tick();
        // flush outranks a memory stall
        mem_stall_req = 1'b1; flush_req = 1'b1;
        #1;
        n_total++;
        if (stall !== 5'b00000 || flush !== 1'b1)
            $display("FAIL flush_over_mem: got stall=%b flush=%b, want 00000 1", stall, flush);
        else n_pass++;
        tick();
        flush_req = 1'b0;
        #1;
        n_total++;
        if (stall !== 5'b01111 || flush !== 1'b0)
            $display("FAIL mem_only: got stall=%b flush=%b, want 01111 0", stall, flush);
        else n_pass++;
        exp_cnt++;
        tick();
        clear_inputs();
        #1;
        n_total++;
        if (stall_cycles !== 32'(exp_cnt))
            $display("FAIL stall_count_running: got %0d, want %0d", stall_cycles, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_div();
        clear_inputs();
        ex_mdu_start = 1'b1; ex_mdu_div = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        n_total++;
        if ({stall, flush, mdu_busy, mdu_done} !== 8'h00)
            $display("FAIL rst_mid_div_outputs: got stall=%b flush=%b busy=%b done=%b, want all 0",
                     stall, flush, mdu_busy, mdu_done);
        else n_pass++;
        tick();
        clear_inputs();
        rst = 1'b0;
        #1;
        n_total++;
        if (stall_cycles !== 32'd0 || mdu_busy !== 1'b0 || mdu_done !== 1'b0 || stall !== 5'b00000)
            $display("FAIL rst_mid_div_after: got cnt=%0d busy=%b done=%b stall=%b, want 0 0 0 00000",
                     stall_cycles, mdu_busy, mdu_done, stall);
        else n_pass++;
        mem_stall_req = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        mem_stall_req = 1'b0;
        #1;
        n_total++;
        if (stall_cycles !== 32'd10)
            $display("FAIL stall_count_10: got %0d, want 10", stall_cycles);
        else n_pass++;
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_cnt = 0;
        clear_inputs();
        rst = 1'b1;
        tick();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_mult();
        test_div_mem();
        test_flush();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
